vehicle_sensor_conditioner: RTL and testbench
=============================================

# vehicle_sensor_conditioner

Upstream conditioning stage for the highway/country-road traffic controller. It turns the raw country-road loop-detector level into the controller's vehicle-request input `x`. It synchronises and debounces the detector and counts waiting vehicles. Vehicles are retired while the controller shows green to the country road, and `x` is held high until the queue drains.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised cycles required to accept a level change (≥2).
- `DEPART_CYCLES`, 3: country-road green cycles per departing vehicle (≥1).
- `QUEUE_W`, 4: width of waiting-vehicle counter.
- `GREEN_CODE`, 2'b10: `cntry_road_signal` encoding meaning green.
- `STUCK_CYCLES`, 64: debounced-high cycles before fault (only with macro).

Ports:
- `clk`, in, 1: single clock, all logic rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `raw_sensor`, in, 1: asynchronous loop-detector level, 1 = vehicle present.
- `cntry_road_signal`, in, 2: country-road lamp state fed back from controller.
- `x`, out, 1: vehicle request to controller.
- `queue_count`, out, QUEUE_W: vehicles waiting.
- `arrival`, out, 1: one-cycle pulse per accepted vehicle.
- `debounced`, out, 1: filtered detector level.
- `sensor_fault`, out, 1: stuck-high detector flag.

## Operation
- Reset values: all outputs 0; internal `sync1`, `sync2`, debounce counter, depart counter and stuck counter are 0.
- Synchroniser: `raw_sensor` → `sync1` → `sync2` (two flops).
- Debounce FSM, 2-bit: `LOW`, `RISE_CHK`, `HIGH`, `FALL_CHK`.
  - `LOW`: go to `RISE_CHK` when `sync2`=1.
  - `RISE_CHK`: count while `sync2`=1. If `sync2`=0, return to `LOW` and clear the count. When the count reaches DEBOUNCE_CYCLES-1 with `sync2`=1, go to `HIGH`, set `debounced`=1, pulse `arrival`.
  - `FALL_CHK` mirrors `RISE_CHK` toward `LOW`. `debounced` drops with no pulse.
- Queue, applied on the same edge as `arrival`:
  - `+1` on arrival; saturates at 2^QUEUE_W-1, and further arrivals are dropped.
- Departure:
  - The depart counter runs while `cntry_road_signal`==GREEN_CODE and `queue_count`≠0. Otherwise it is held at 0.
  - At DEPART_CYCLES-1 the queue decrements by 1 and the counter clears.
  - Arrival and departure on the same edge: `queue_count` is unchanged and the depart counter still clears.
- `x` = `queue_count`≠0 (combinational from the register), OR `sensor_fault`.
- Reset asserted mid-debounce or mid-departure clears everything on the next edge. The FSM returns to `LOW` and the queue empties.

## Timing
- `raw_sensor` sampled high at edge k and held: `sync2`=1 after k+1. `debounced`, `arrival`, `queue_count`++ and `x` all change after edge k+DEBOUNCE_CYCLES+1 (k+5 at default).
- A pulse on `sync2` shorter than DEBOUNCE_CYCLES cycles is rejected entirely.
- A vehicle departs every DEPART_CYCLES green cycles. `x` falls on the edge where `queue_count` goes 1→0.
- `arrival` is exactly one cycle wide.

## Configuration
- `SENSOR_STUCK_DET_EN` defined:
  - The stuck counter counts cycles with `debounced`=1 and clears when `debounced`=0.
  - On reaching STUCK_CYCLES it sets `sensor_fault`=1, sticky until reset. `x` is then forced to 1 as fail-safe service.
  - Queue counting continues normally.
- `SENSOR_STUCK_DET_EN` undefined: no stuck counter is built, and `sensor_fault` is tied to 0.

## Test plan
- Reset:
  - Drive `reset`=1 for 2 edges with `raw_sensor`=1 → all outputs 0.
  - After release, `debounced` rises only DEBOUNCE_CYCLES+2 edges later.
- Glitch rejection: `raw_sensor` high 3 cycles then low (DEBOUNCE_CYCLES=4) → no `arrival`, `queue_count` stays 0, `x`=0.
- Valid car and service:
  - `raw_sensor` high 10 cycles → one `arrival` pulse 5 edges after sampling; `queue_count`=1, `x`=1.
  - Then `cntry_road_signal`=2'b10 → `queue_count`=0 and `x`=0 after 3 green edges.
- Three cars and simultaneous events:
  - Three debounced vehicles give `queue_count`=3.
  - An arrival coinciding with a departure edge leaves the count at 3.
  - Green held for 9 more cycles with no further arrivals → count 0.
- Saturation: 17 arrivals with QUEUE_W=4 → `queue_count`=15, no wrap to 0.
- Stuck detection (macro on, STUCK_CYCLES=64): hold `raw_sensor` high 80 cycles → `sensor_fault`=1 and `x` remains 1 even after the queue drains under green. Clears only on `reset`.

Source files
------------

// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner: synchronise/debounce loop detector, queue vehicles, drive request x.
// Optional stuck-high detector enabled by SENSOR_STUCK_DET_EN.
module vehicle_sensor_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         DEPART_CYCLES   = 3,
  parameter int         QUEUE_W         = 4,
  parameter logic [1:0] GREEN_CODE      = 2'b10,
  parameter int         STUCK_CYCLES    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               raw_sensor,
  input  logic [1:0]         cntry_road_signal,
  output logic               x,
  output logic [QUEUE_W-1:0] queue_count,
  output logic               arrival,
  output logic               debounced,
  output logic               sensor_fault
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(DEPART_CYCLES + 1);
  typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;
  state_t state, state_n;
  logic sync1, sync2, rise, run, depart;
  logic [DW-1:0] cnt, cnt_n;
  logic [PW-1:0] pcnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= LOW;
      cnt <= '0;
    end else begin
      sync1 <= raw_sensor;
      sync2 <= sync1;
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // The first stable sample is counted on entry to a check state.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rise = 1'b0;
    unique case (state)
      LOW: if (sync2) begin
        state_n = RISE_CHK;
        cnt_n = DW'(1);
      end
      RISE_CHK: if (!sync2) begin
        state_n = LOW;
        cnt_n = '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        state_n = HIGH;
        cnt_n = '0;
        rise = 1'b1;
      end else cnt_n = cnt + DW'(1);
      HIGH: if (!sync2) begin
        state_n = FALL_CHK;
        cnt_n = DW'(1);
      end
      FALL_CHK: if (sync2) begin
        state_n = HIGH;
        cnt_n = '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        state_n = LOW;
        cnt_n = '0;
      end else cnt_n = cnt + DW'(1);
    endcase
  end
  assign debounced = (state == HIGH) || (state == FALL_CHK);
  assign run = (cntry_road_signal == GREEN_CODE) && (queue_count != '0);
  assign depart = run && (pcnt == PW'(DEPART_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      arrival <= 1'b0;
      pcnt <= '0;
      queue_count <= '0;
    end else begin
      arrival <= rise;
      pcnt <= (!run || depart) ? '0 : pcnt + PW'(1);
      if (rise && !depart && queue_count != '1) queue_count <= queue_count + QUEUE_W'(1);
      else if (depart && !rise) queue_count <= queue_count - QUEUE_W'(1);
    end
  end
`ifdef SENSOR_STUCK_DET_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  logic [SW-1:0] scnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt <= '0;
      sensor_fault <= 1'b0;
    end else begin
      scnt <= !debounced ? '0 : (scnt == SW'(STUCK_CYCLES)) ? scnt : scnt + SW'(1);
      if (debounced && scnt == SW'(STUCK_CYCLES - 1)) sensor_fault <= 1'b1;
    end
  end
`else
  assign sensor_fault = (STUCK_CYCLES < 0);
`endif
  assign x = (queue_count != '0) || sensor_fault;
endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// tb_vehicle_sensor_conditioner: directed checks of debounce, queueing, departure and saturation.
module tb_vehicle_sensor_conditioner;
  logic clk, reset, raw_sensor, x, arrival, debounced, sensor_fault;
  logic [1:0] cntry_road_signal;
  logic [3:0] queue_count;
  int checks = 0, errors = 0, arr_cnt = 0, arr_base;
`ifdef SENSOR_STUCK_DET_EN
  localparam logic STUCK_EXP = 1'b1;
`else
  localparam logic STUCK_EXP = 1'b0;
`endif
  vehicle_sensor_conditioner dut (
    .clk(clk), .reset(reset), .raw_sensor(raw_sensor), .cntry_road_signal(cntry_road_signal),
    .x(x), .queue_count(queue_count), .arrival(arrival), .debounced(debounced),
    .sensor_fault(sensor_fault)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (!reset && arrival) arr_cnt <= arr_cnt + 1;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic car();
    raw_sensor = 1'b1;
    step(7);
    raw_sensor = 1'b0;
    step(7);
  endtask
  initial begin
    reset = 1'b1;
    raw_sensor = 1'b1;
    cntry_road_signal = 2'b00;
    step(2);
    chk("rst_x", 8'(x), 8'd0);
    chk("rst_q", 8'(queue_count), 8'd0);
    chk("rst_arr", 8'(arrival), 8'd0);
    chk("rst_deb", 8'(debounced), 8'd0);
    chk("rst_fault", 8'(sensor_fault), 8'd0);
    reset = 1'b0;
    step(5);
    chk("deb_early", 8'(debounced), 8'd0);
    chk("x_early", 8'(x), 8'd0);
    step(1);
    chk("deb_rise", 8'(debounced), 8'd1);
    chk("arr_pulse", 8'(arrival), 8'd1);
    chk("q_one", 8'(queue_count), 8'd1);
    chk("x_one", 8'(x), 8'd1);
    step(1);
    chk("arr_width", 8'(arrival), 8'd0);
    raw_sensor = 1'b0;
    step(5);
    chk("deb_hold", 8'(debounced), 8'd1);
    step(1);
    chk("deb_fall", 8'(debounced), 8'd0);
    chk("fall_no_arr", 8'(arrival), 8'd0);
    cntry_road_signal = 2'b10;
    step(2);
    chk("svc_wait", 8'(queue_count), 8'd1);
    step(1);
    chk("svc_q", 8'(queue_count), 8'd0);
    chk("svc_x", 8'(x), 8'd0);
    cntry_road_signal = 2'b00;
    arr_base = arr_cnt;
    raw_sensor = 1'b1;
    step(3);
    raw_sensor = 1'b0;
    step(10);
    chk("glitch_arr", 8'(arr_cnt - arr_base), 8'd0);
    chk("glitch_q", 8'(queue_count), 8'd0);
    chk("glitch_x", 8'(x), 8'd0);
    repeat (3) car();
    chk("three_q", 8'(queue_count), 8'd3);
    raw_sensor = 1'b1;
    step(3);
    cntry_road_signal = 2'b10;
    step(3);
    chk("sim_arr", 8'(arrival), 8'd1);
    chk("sim_q", 8'(queue_count), 8'd3);
    raw_sensor = 1'b0;
    step(2);
    chk("sim_clear", 8'(queue_count), 8'd3);
    step(1);
    chk("dep_next", 8'(queue_count), 8'd2);
    step(6);
    chk("drain_q", 8'(queue_count), 8'd0);
    chk("drain_x", 8'(x), 8'd0);
    cntry_road_signal = 2'b00;
    step(8);
    arr_base = arr_cnt;
    repeat (17) car();
    chk("sat_arrivals", 8'(arr_cnt - arr_base), 8'd17);
    chk("sat_q", 8'(queue_count), 8'd15);
    chk("sat_x", 8'(x), 8'd1);
    cntry_road_signal = 2'b10;
    raw_sensor = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    chk("midrst_q", 8'(queue_count), 8'd0);
    chk("midrst_x", 8'(x), 8'd0);
    chk("midrst_deb", 8'(debounced), 8'd0);
    reset = 1'b0;
    cntry_road_signal = 2'b00;
    step(80);
    chk("stuck_fault", 8'(sensor_fault), 8'(STUCK_EXP));
    chk("stuck_q", 8'(queue_count), 8'd1);
    raw_sensor = 1'b0;
    cntry_road_signal = 2'b10;
    step(10);
    chk("stuck_drain_q", 8'(queue_count), 8'd0);
    chk("stuck_x", 8'(x), 8'(STUCK_EXP));
    reset = 1'b1;
    step(1);
    chk("stuck_rst", 8'(sensor_fault), 8'd0);
    chk("stuck_rst_x", 8'(x), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
